// File: rtl/disp_src_sched_pkg.sv
// rtl/disp_src_sched_pkg.sv - shared state type and default constants for disp_src_sched
package disp_src_sched_pkg;

  typedef enum logic [1:0] {MANUAL, AUTO, HOLD} sched_state_t;

  localparam int DWELL_DEFAULT = 100_000_000;
  localparam int BLANK_DEFAULT = 1_000_000;
  localparam int SYNC_DEFAULT  = 2;

endpackage

// File: rtl/sync_edge_detect.sv
// rtl/sync_edge_detect.sv - multi-flop synchronizer with registered level and rising-edge outputs
module sync_edge_detect #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic level,
  output logic rise
);

  logic [STAGES-1:0] chain;

  // level/rise are registered once more so every input reaches the FSM at edge k+STAGES+1
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chain <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
    end else begin
      chain <= {chain[STAGES-2:0], din};
      level <= chain[STAGES-1];
      rise  <= chain[STAGES-1] & ~level;
    end
  end

endmodule

// File: rtl/disp_src_sched.sv
// rtl/disp_src_sched.sv - manual/auto/hold sequencer driving the display-source mux select
// Optional display blanking after each switch is enabled with DISP_SRC_SCHED_BLANK_EN.
module disp_src_sched
  import disp_src_sched_pkg::*;
#(
  parameter int DWELL_CYCLES = DWELL_DEFAULT,
  parameter int BLANK_CYCLES = BLANK_DEFAULT,
  parameter int SYNC_STAGES  = SYNC_DEFAULT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic mode_auto,
  input  logic sel_btn,
  input  logic hold,
  output logic ctrl,
  output logic switch_pulse,
  output logic blank
);

  localparam int CNT_W = $clog2(DWELL_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL_CYCLES - 1);

  if (DWELL_CYCLES < 2) begin : g_chk_dwell
    $error("DWELL_CYCLES must be >= 2");
  end
  if (BLANK_CYCLES < 1 || BLANK_CYCLES >= DWELL_CYCLES) begin : g_chk_blank
    $error("BLANK_CYCLES must be >= 1 and < DWELL_CYCLES");
  end
  if (SYNC_STAGES < 2) begin : g_chk_sync
    $error("SYNC_STAGES must be >= 2");
  end

  logic mode_lvl, hold_lvl, press;
  logic unused_mode_rise, unused_hold_rise, unused_sel_level;

  sync_edge_detect #(.STAGES(SYNC_STAGES)) u_sync_mode (
    .clk(clk), .reset_n(reset_n), .din(mode_auto), .level(mode_lvl), .rise(unused_mode_rise)
  );
  sync_edge_detect #(.STAGES(SYNC_STAGES)) u_sync_sel (
    .clk(clk), .reset_n(reset_n), .din(sel_btn), .level(unused_sel_level), .rise(press)
  );
  sync_edge_detect #(.STAGES(SYNC_STAGES)) u_sync_hold (
    .clk(clk), .reset_n(reset_n), .din(hold), .level(hold_lvl), .rise(unused_hold_rise)
  );

  sched_state_t     state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             toggle;

  // A state transition always wins over a press arriving in the same cycle.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    toggle    = 1'b0;
    if (!mode_lvl) begin
      if (state != MANUAL) begin
        state_nxt = MANUAL;
        cnt_nxt   = '0;
      end else begin
        toggle = press;
      end
    end else begin
      case (state)
        MANUAL: begin
          state_nxt = hold_lvl ? HOLD : AUTO;
          cnt_nxt   = '0;
        end
        AUTO: begin
          if (hold_lvl) begin
            state_nxt = HOLD;
          end else if (press || cnt == CNT_LAST) begin
            toggle  = 1'b1;
            cnt_nxt = '0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        HOLD: begin
          if (!hold_lvl) state_nxt = AUTO;
          else           toggle    = press;
        end
        default: begin
          state_nxt = MANUAL;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= MANUAL;
      cnt          <= '0;
      ctrl         <= 1'b0;
      switch_pulse <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      ctrl         <= ctrl ^ toggle;
      switch_pulse <= toggle;
    end
  end

`ifdef DISP_SRC_SCHED_BLANK_EN
  localparam int BLK_W = $clog2(BLANK_CYCLES) + 1;
  logic [BLK_W-1:0] blank_left;

  // blank_left counts the cycles still owed after the current one; a new toggle restarts it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blank_left <= '0;
      blank      <= 1'b0;
    end else if (toggle) begin
      blank_left <= BLK_W'(BLANK_CYCLES - 1);
      blank      <= 1'b1;
    end else if (blank_left != '0) begin
      blank_left <= blank_left - BLK_W'(1);
    end else begin
      blank <= 1'b0;
    end
  end
`else
  assign blank = 1'b0;
`endif

endmodule

// File: tb/tb_disp_src_sched.sv
// tb/tb_disp_src_sched.sv - vector table, directed corner sequences and randomized model check for disp_src_sched
module tb_disp_src_sched;

  localparam int D   = 8;
  localparam int B   = 3;
  localparam int S   = 2;
  localparam int LAG = S + 1;

`ifdef DISP_SRC_SCHED_BLANK_EN
  localparam int EXP_BLANK_ONE = 3;
  localparam int EXP_BLANK_TWO = 5;
`else
  localparam int EXP_BLANK_ONE = 0;
  localparam int EXP_BLANK_TWO = 0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic mode_auto = 1'b0;
  logic sel_btn = 1'b0;
  logic hold = 1'b0;
  logic ctrl, switch_pulse, blank;

  always #5 clk = ~clk;

  disp_src_sched #(.DWELL_CYCLES(D), .BLANK_CYCLES(B), .SYNC_STAGES(S)) dut (
    .clk(clk), .reset_n(reset_n), .mode_auto(mode_auto), .sel_btn(sel_btn), .hold(hold),
    .ctrl(ctrl), .switch_pulse(switch_pulse), .blank(blank)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: inputs seen by the controller are the board inputs delayed by LAG edges.
  int         edge_n;
  int         m_st;     // 0 manual, 1 auto, 2 hold
  int         m_cnt;
  logic       m_ctrl, m_pulse;
  int         blank_end;
  logic [7:0] hm, hs, hh;

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0b required=%0b edge=%0d", name, act, exp, edge_n);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d edge=%0d", name, act, exp, edge_n);
    end
  endtask

  function automatic void model_reset();
    edge_n = 0; m_st = 0; m_cnt = 0; m_ctrl = 1'b0; m_pulse = 1'b0; blank_end = 0;
    hm = '0; hs = '0; hh = '0;
  endfunction

  function automatic logic m_blank();
`ifdef DISP_SRC_SCHED_BLANK_EN
    return (edge_n < blank_end);
`else
    return 1'b0;
`endif
  endfunction

  function automatic void model_step();
    logic lm, lh, pr, tog;
    edge_n++;
    hm = {hm[6:0], mode_auto};
    hs = {hs[6:0], sel_btn};
    hh = {hh[6:0], hold};
    lm = hm[LAG];
    lh = hh[LAG];
    pr = hs[LAG] & ~hs[LAG+1];
    tog = 1'b0;
    if (!lm) begin
      if (m_st != 0) begin m_st = 0; m_cnt = 0; end
      else tog = pr;
    end else if (m_st == 0) begin
      m_st = lh ? 2 : 1;
      m_cnt = 0;
    end else if (m_st == 1) begin
      if (lh) m_st = 2;
      else if (pr || m_cnt == D - 1) begin tog = 1'b1; m_cnt = 0; end
      else m_cnt++;
    end else begin
      if (!lh) m_st = 1;
      else tog = pr;
    end
    m_ctrl  = m_ctrl ^ tog;
    m_pulse = tog;
    if (tog) blank_end = edge_n + B;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("ctrl", ctrl, m_ctrl);
    check("switch_pulse", switch_pulse, m_pulse);
    check("blank", blank, m_blank());
  endtask

  task automatic async_reset();
    #2 reset_n = 1'b0;
    #1;
    check("rst_ctrl", ctrl, 1'b0);
    check("rst_pulse", switch_pulse, 1'b0);
    check("rst_blank", blank, 1'b0);
    model_reset();
    #1 reset_n = 1'b1;
  endtask

  typedef struct {
    logic m, s, h;
    int   n;
    logic exp_ctrl, exp_pulse;
  } vec_t;

  vec_t tbl[16];

  initial begin
    int first_pulse, second_pulse, npulse, nblank, t;

    tbl[0]  = '{1'b0, 1'b1, 1'b0, 2, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 1, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 1, 1'b1, 1'b1};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 1, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 6, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 3, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b1};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 3, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 1, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 7, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 1, 1'b1, 1'b1};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 8, 1'b0, 1'b1};
    tbl[13] = '{1'b1, 1'b0, 1'b0, 8, 1'b1, 1'b1};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 3, 1'b1, 1'b0};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 1, 1'b1, 1'b0};

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_ctrl", ctrl, 1'b0);
    check("reset_pulse", switch_pulse, 1'b0);
    check("reset_blank", blank, 1'b0);
    reset_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      mode_auto = tbl[i].m; sel_btn = tbl[i].s; hold = tbl[i].h;
      repeat (tbl[i].n) tick();
      check($sformatf("tbl%0d_ctrl", i), ctrl, tbl[i].exp_ctrl);
      check($sformatf("tbl%0d_pulse", i), switch_pulse, tbl[i].exp_pulse);
    end

    // Reset in AUTO at count 5 with ctrl high, then confirm a full re-entry from MANUAL.
    mode_auto = 1'b1; hold = 1'b0; sel_btn = 1'b0;
    t = 0;
    while (t < 40 && !(m_st == 1 && m_cnt == 5 && m_ctrl == 1'b1)) begin tick(); t++; end
    check_int("reach_auto_cnt5", t < 40, 1);
    async_reset();
    first_pulse = 0;
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (switch_pulse && first_pulse == 0) first_pulse = k;
    end
    check_int("post_reset_first_toggle", first_pulse, LAG + 1 + D);

    // HOLD entered with the counter at 5; resume toggles 3 cycles after AUTO re-entry.
    t = 0;
    while (t < 20 && !(m_st == 1 && m_cnt == 2)) begin tick(); t++; end
    check_int("reach_auto_cnt2", t < 20, 1);
    hold = 1'b1;
    npulse = 0;
    for (int k = 0; k < 24; k++) begin tick(); npulse += switch_pulse; end
    check_int("hold_no_toggle", npulse, 0);
    hold = 1'b0;
    first_pulse = 0;
    for (int k = 1; k <= 20 && first_pulse == 0; k++) begin
      tick();
      if (switch_pulse) first_pulse = k;
    end
    check_int("hold_resume_toggle", first_pulse, LAG + 1 + 3);

    // Press event lands on terminal count: single toggle, next one a full dwell later.
    t = 0;
    while (t < 20 && !(m_st == 1 && m_cnt == 4)) begin tick(); t++; end
    check_int("reach_auto_cnt4", t < 20, 1);
    sel_btn = 1'b1;
    first_pulse = 0; second_pulse = 0; npulse = 0;
    for (int k = 1; k <= 19; k++) begin
      tick();
      sel_btn = 1'b0;
      if (switch_pulse) begin
        npulse++;
        if (first_pulse == 0) first_pulse = k;
        else if (second_pulse == 0) second_pulse = k;
      end
    end
    check_int("tc_press_first", first_pulse, 4);
    check_int("tc_press_second", second_pulse, 12);
    check_int("tc_press_count", npulse, 2);

    // Blank lengths: one toggle, then two toggles two cycles apart.
    mode_auto = 1'b0;
    repeat (6) tick();
    nblank = 0;
    sel_btn = 1'b1; tick(); nblank += blank;
    sel_btn = 1'b0;
    for (int k = 0; k < 9; k++) begin tick(); nblank += blank; end
    check_int("blank_single", nblank, EXP_BLANK_ONE);
    nblank = 0;
    sel_btn = 1'b1; tick(); nblank += blank;
    sel_btn = 1'b0; tick(); nblank += blank;
    sel_btn = 1'b1; tick(); nblank += blank;
    sel_btn = 1'b0;
    for (int k = 0; k < 9; k++) begin tick(); nblank += blank; end
    check_int("blank_double", nblank, EXP_BLANK_TWO);

    // Randomized run against the model, with occasional asynchronous resets.
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 39) == 0) mode_auto = ~mode_auto;
      if ($urandom_range(0, 29) == 0) hold = ~hold;
      if ($urandom_range(0, 3) == 0) sel_btn = ~sel_btn;
      tick();
      if ($urandom_range(0, 499) == 0) async_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
